// File: rtl/microprogram_sequencer.sv
// Next-microaddress sequencer: picks the next microstore address from the decoder, an
// incrementer, a jump target or a micro-subroutine return stack; all outputs registered.
module microprogram_sequencer #(
    parameter int unsigned STATE_W = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [STATE_W-1:0] RESET_STATE = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [STATE_W-1:0]                 enc_state,
    input  logic [STATE_W-1:0]                 cr_addr,
    input  logic [2:0]                         ns_sel,
    input  logic                               cond_in,
    input  logic                               inv,
    output logic [STATE_W-1:0]                 state,
    output logic [$clog2(STACK_DEPTH):0]       stack_cnt,
    output logic                               err
);

    localparam int unsigned CNT_W = $clog2(STACK_DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        SelEnc   = 3'b000,
        SelInc   = 3'b001,
        SelJmp   = 3'b010,
        SelCjmp  = 3'b011,
        SelCwait = 3'b100,
        SelCall  = 3'b101,
        SelRet   = 3'b110,
        SelRst   = 3'b111
    } ns_sel_e;

    logic [STATE_W-1:0] stack_q [STACK_DEPTH];
    logic [STATE_W-1:0] state_q, state_d, inc;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_dec;
    logic               err_q, err_d;
    logic               push, t;
    logic [PTR_W-1:0]   push_idx, top_idx;

    assign inc      = state_q + STATE_W'(1);
    assign t        = cond_in ^ inv;
    assign cnt_dec  = cnt_q - CNT_W'(1);
    // Only used when the stack is not full / not empty, so truncation is safe.
    assign push_idx = cnt_q[PTR_W-1:0];
    assign top_idx  = cnt_dec[PTR_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push    = 1'b0;
        unique case (ns_sel_e'(ns_sel))
            SelEnc:   state_d = enc_state;
            SelInc:   state_d = inc;
            SelJmp:   state_d = cr_addr;
            SelCjmp:  state_d = t ? cr_addr : inc;
            SelCwait: state_d = t ? inc : state_q;
            SelCall: begin
                state_d = cr_addr;
                if (cnt_q == CNT_W'(STACK_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SelRet: begin
                if (cnt_q == '0) begin
                    state_d = RESET_STATE;
                    err_d   = 1'b1;
                end else begin
                    state_d = stack_q[top_idx];
                    cnt_d   = cnt_dec;
                end
            end
            SelRst: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Stack contents need no reset; stack_cnt alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack_q[push_idx] <= inc;
        end
    end

    assign state     = state_q;
    assign stack_cnt = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Bench for microprogram_sequencer: directed literal cases plus random stimulus checked
// every cycle against a queue-based behavioural model.
module tb_microprogram_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] enc_state = 8'd0;
    logic [7:0] cr_addr = 8'd0;
    logic [2:0] ns_sel = 3'd0;
    logic       cond_in = 1'b0;
    logic       inv = 1'b0;
    logic [7:0] state;
    logic [2:0] stack_cnt;
    logic       err;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    logic [7:0] m_state;
    logic [7:0] m_stack[$];
    logic       m_err;

    localparam logic [2:0] ENC = 3'd0, INC = 3'd1, JMP = 3'd2, CJMP = 3'd3;
    localparam logic [2:0] CWAIT = 3'd4, CALL = 3'd5, RET = 3'd6, RST = 3'd7;

    microprogram_sequencer #(
        .STATE_W(8),
        .STACK_DEPTH(4),
        .RESET_STATE(8'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enc_state(enc_state),
        .cr_addr(cr_addr),
        .ns_sel(ns_sel),
        .cond_in(cond_in),
        .inv(inv),
        .state(state),
        .stack_cnt(stack_cnt),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the sequencer must do, from its rules.
    always @(posedge clk) begin
        logic [7:0] nxt_inc;
        logic       tst;
        nxt_inc = m_state + 8'd1;
        tst = cond_in ^ inv;
        if (reset) begin
            m_state = 8'd0;
            m_stack.delete();
            m_err = 1'b0;
        end else begin
            case (ns_sel)
                ENC:   m_state = enc_state;
                INC:   m_state = nxt_inc;
                JMP:   m_state = cr_addr;
                CJMP:  m_state = tst ? cr_addr : nxt_inc;
                CWAIT: m_state = tst ? nxt_inc : m_state;
                CALL: begin
                    if (m_stack.size() == 4) m_err = 1'b1;
                    else m_stack.push_back(nxt_inc);
                    m_state = cr_addr;
                end
                RET: begin
                    if (m_stack.size() == 0) begin
                        m_state = 8'd0;
                        m_err = 1'b1;
                    end else begin
                        m_state = m_stack.pop_back();
                    end
                end
                default: begin
                    m_state = 8'd0;
                    m_stack.delete();
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_state", 32'(state), 32'(m_state));
            chk("model_cnt", 32'(stack_cnt), 32'(m_stack.size()));
            chk("model_err", 32'(err), 32'(m_err));
        end
    end

    task automatic cyc(input logic rst, input logic [2:0] sel, input logic [7:0] enc,
                       input logic [7:0] cr, input logic c, input logic i);
        reset = rst;
        ns_sel = sel;
        enc_state = enc;
        cr_addr = cr;
        cond_in = c;
        inv = i;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string name, input logic [7:0] s, input logic [2:0] n,
                           input logic e);
        chk({name, "_state"}, 32'(state), 32'(s));
        chk({name, "_cnt"}, 32'(stack_cnt), 32'(n));
        chk({name, "_err"}, 32'(err), 32'(e));
    endtask

    initial begin
        // Reset with ENC selected, then leave reset.
        cyc(1'b1, ENC, 8'd10, 8'd0, 1'b0, 1'b0);
        checking = 1'b1;
        expect3("reset", 8'd0, 3'd0, 1'b0);
        cyc(1'b0, ENC, 8'd10, 8'd0, 1'b0, 1'b0);
        chk("enc_10", 32'(state), 32'd10);

        cyc(1'b0, JMP, 8'd0, 8'd255, 1'b0, 1'b0);
        chk("jmp_255", 32'(state), 32'd255);
        cyc(1'b0, INC, 8'd0, 8'd0, 1'b0, 1'b0);
        chk("inc_wrap", 32'(state), 32'd0);

        cyc(1'b0, JMP, 8'd0, 8'd5, 1'b0, 1'b0);
        cyc(1'b0, CJMP, 8'd0, 8'd40, 1'b0, 1'b0);
        chk("cjmp_fall", 32'(state), 32'd6);
        cyc(1'b0, JMP, 8'd0, 8'd5, 1'b0, 1'b0);
        cyc(1'b0, CJMP, 8'd0, 8'd40, 1'b0, 1'b1);
        chk("cjmp_take", 32'(state), 32'd40);

        cyc(1'b0, JMP, 8'd0, 8'd19, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, CWAIT, 8'd0, 8'd0, 1'b0, 1'b0);
            chk("cwait_hold", 32'(state), 32'd19);
        end
        cyc(1'b0, CWAIT, 8'd0, 8'd0, 1'b1, 1'b0);
        chk("cwait_go", 32'(state), 32'd20);

        // Nested subroutine calls.
        cyc(1'b0, JMP, 8'd0, 8'd7, 1'b0, 1'b0);
        cyc(1'b0, CALL, 8'd0, 8'd60, 1'b0, 1'b0);
        expect3("call1", 8'd60, 3'd1, 1'b0);
        cyc(1'b0, CALL, 8'd0, 8'd80, 1'b0, 1'b0);
        expect3("call2", 8'd80, 3'd2, 1'b0);
        cyc(1'b0, RET, 8'd0, 8'd0, 1'b0, 1'b0);
        expect3("ret1", 8'd61, 3'd1, 1'b0);
        cyc(1'b0, RET, 8'd0, 8'd0, 1'b0, 1'b0);
        expect3("ret2", 8'd8, 3'd0, 1'b0);

        // Overflow: five calls from state 0 into 100..104.
        cyc(1'b1, ENC, 8'd0, 8'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b0, CALL, 8'd0, 8'(100 + k), 1'b0, 1'b0);
        expect3("ovf", 8'd104, 3'd4, 1'b1);
        cyc(1'b0, RET, 8'd0, 8'd0, 1'b0, 1'b0);
        expect3("pop1", 8'd103, 3'd3, 1'b1);
        cyc(1'b0, RET, 8'd0, 8'd0, 1'b0, 1'b0);
        expect3("pop2", 8'd102, 3'd2, 1'b1);
        cyc(1'b0, RET, 8'd0, 8'd0, 1'b0, 1'b0);
        expect3("pop3", 8'd101, 3'd1, 1'b1);
        cyc(1'b0, RET, 8'd0, 8'd0, 1'b0, 1'b0);
        expect3("pop4", 8'd1, 3'd0, 1'b1);
        cyc(1'b0, RET, 8'd0, 8'd0, 1'b0, 1'b0);
        expect3("udf", 8'd0, 3'd0, 1'b1);

        // Reset in the middle of a call chain discards the stack and clears err.
        cyc(1'b0, CALL, 8'd0, 8'd50, 1'b0, 1'b0);
        cyc(1'b0, CALL, 8'd0, 8'd70, 1'b0, 1'b0);
        cyc(1'b1, CALL, 8'd0, 8'd90, 1'b0, 1'b0);
        expect3("mid_reset", 8'd0, 3'd0, 1'b0);
        cyc(1'b0, RET, 8'd0, 8'd0, 1'b0, 1'b0);
        expect3("ret_after_reset", 8'd0, 3'd0, 1'b1);

        // RST select clears the stack but keeps err.
        cyc(1'b0, CALL, 8'd0, 8'd33, 1'b0, 1'b0);
        cyc(1'b0, RST, 8'd0, 8'd0, 1'b0, 1'b0);
        expect3("rst_sel", 8'd0, 3'd0, 1'b1);

        for (int k = 0; k < 4000; k++) begin
            cyc(($urandom_range(0, 63) == 0), 3'($urandom_range(0, 7)), 8'($urandom),
                8'($urandom), 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
